// File: rtl/spi_rd_master_arb_if.sv
// Bus bundle between the readback arbiter and its environment:
// two local read requesters on one side, the shared SPI readback bus on the other.
interface spi_rd_master_arb_if #(
  parameter int NBIT = 8
);
  // Handshake: req is a level held until its one-cycle done pulse; adr is sampled
  // on the grant edge only; rdata is valid with done and held until the next capture.
  logic            req0;
  logic [7:0]      adr0;
  logic            req1;
  logic [7:0]      adr1;
  logic            done0;
  logic            done1;
  logic [NBIT-1:0] rdata;
  logic            busy;
  logic            cs;
  logic            sclk;
  logic            mosi;
  logic            miso;

  modport master (
    input  req0, adr0, req1, adr1, miso,
    output done0, done1, rdata, busy, cs, sclk, mosi
  );

  modport slave (
    output req0, adr0, req1, adr1, miso,
    input  done0, done1, rdata, busy, cs, sclk, mosi
  );
endinterface

// File: rtl/spi_rd_master_arb.sv
// Round-robin two-requester SPI read master: sends an 8-bit slave address,
// then shifts in an NBIT status word and returns it to the granted requester.
module spi_rd_master_arb #(
  parameter int NBIT   = 8,
  parameter int CLKDIV = 4,
  parameter int CS_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_rd_master_arb_if.master   bus,
  output logic [2:0]            dbg_state
);
  localparam int CMAX = (CLKDIV > CS_GAP) ? CLKDIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BMAX = (NBIT > 8) ? NBIT : 8;
  localparam int BW   = $clog2(BMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ADDR, DATA, HOLD, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  logic [7:0]      adr_sh;
  logic [NBIT-1:0] cap;
  logic            miso_s1;
  logic            miso_s2;
  logic            rr_pref;
  logic            owner;
  logic            pick;
  logic            phase_end;

  assign dbg_state = state;
  assign phase_end = (cnt == CW'(CLKDIV - 1));

  // rr_pref names the requester that wins a tie; it flips away from every winner.
  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) pick = rr_pref;
  end

  // miso idles high, so the synchroniser resets to ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso_s1 <= 1'b1;
      miso_s2 <= 1'b1;
    end else begin
      miso_s1 <= bus.miso;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      adr_sh    <= '0;
      cap       <= '0;
      rr_pref   <= 1'b0;
      owner     <= 1'b0;
      bus.cs    <= 1'b1;
      bus.sclk  <= 1'b0;
      bus.mosi  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.busy  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner    <= pick;
            rr_pref  <= ~pick;
            adr_sh   <= pick ? bus.adr1 : bus.adr0;
            bus.mosi <= pick ? bus.adr1[7] : bus.adr0[7];
            bus.cs   <= 1'b0;
            bus.sclk <= 1'b0;
            bus.busy <= 1'b1;
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            bus.mosi <= adr_sh[7];
            adr_sh   <= {adr_sh[6:0], 1'b0};
            state    <= ADDR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ADDR, DATA: begin
          if (!phase_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!bus.sclk) begin
              bus.sclk <= 1'b1;
              if (state == DATA) cap <= (cap << 1) | NBIT'(miso_s2);
            end else begin
              // End of a bit: sclk falls and the next low phase begins.
              bus.sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (state == ADDR) begin
                if (bit_cnt == BW'(7)) begin
                  bus.mosi <= 1'b0;
                  bit_cnt  <= '0;
                  state    <= DATA;
                end else begin
                  bus.mosi <= adr_sh[7];
                  adr_sh   <= {adr_sh[6:0], 1'b0};
                end
              end else if (bit_cnt == BW'(NBIT - 1)) begin
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            cnt       <= '0;
            bus.cs    <= 1'b1;
            bus.rdata <= cap;
            bus.done0 <= ~owner;
            bus.done1 <= owner;
            state     <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(CS_GAP - 1)) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rd_master_arb.sv
// Bench for spi_rd_master_arb: default build (CLKDIV=4, NBIT=8) driven with directed
// and random reads, plus a CLKDIV=3/NBIT=16 build for a single timing read.
`timescale 1ns/1ps
module tb_spi_rd_master_arb;
  localparam int NA = 8;
  localparam int CA = 4;
  localparam int GA = 2;
  localparam int NB = 16;
  localparam int CB = 3;
  localparam int GB = 2;

  typedef struct {
    int   run;
    logic sp;
    logic mp;
    int   rises;
    int   cslow;
    bit   first;
  } tmon_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_rd_master_arb_if #(.NBIT(NA)) ba();
  spi_rd_master_arb_if #(.NBIT(NB)) bb();
  logic [2:0] dbg_a;
  logic [2:0] dbg_b;

  spi_rd_master_arb #(.NBIT(NA), .CLKDIV(CA), .CS_GAP(GA)) dut_a (
    .clk(clk), .rst(rst), .bus(ba), .dbg_state(dbg_a));
  spi_rd_master_arb #(.NBIT(NB), .CLKDIV(CB), .CS_GAP(GB)) dut_b (
    .clk(clk), .rst(rst), .bus(bb), .dbg_state(dbg_b));

  // scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [NA-1:0] exp_q[$];
  logic [NA-1:0] mem_a[256];
  bit            mem_v[256];
  logic [NB-1:0] b_word;
  bit            pref;
  logic [NA-1:0] last_rdata;
  int            last_done;
  int            dc0 = 0;
  int            dc1 = 0;

  always @(negedge clk) begin
    if (ba.done0 === 1'b1) dc0++;
    if (ba.done1 === 1'b1) dc1++;
  end

  // Readback slaves: capture the address on sclk rises, present data after falls.
  int         sa_bits;
  logic [7:0] sa_adr;
  logic [7:0] sa_last;
  logic       sa_sclk;
  always @(ba.cs or ba.sclk) begin
    if (ba.cs !== 1'b0) begin
      sa_bits = 0; sa_adr = '0; sa_sclk = 1'b0; ba.miso = 1'b1;
    end else if (ba.sclk === 1'b1 && sa_sclk == 1'b0) begin
      sa_sclk = 1'b1;
      if (sa_bits < 8) sa_adr = {sa_adr[6:0], ba.mosi};
      sa_bits++;
      if (sa_bits == 8) sa_last = sa_adr;
    end else if (ba.sclk === 1'b0 && sa_sclk == 1'b1) begin
      sa_sclk = 1'b0;
      if (sa_bits >= 8 && sa_bits < 8 + NA && mem_v[sa_adr])
        ba.miso = mem_a[sa_adr][NA-1-(sa_bits-8)];
      else
        ba.miso = 1'b1;
    end
  end

  int         sb_bits;
  logic [7:0] sb_adr;
  logic [7:0] sb_last;
  logic       sb_sclk;
  always @(bb.cs or bb.sclk) begin
    if (bb.cs !== 1'b0) begin
      sb_bits = 0; sb_adr = '0; sb_sclk = 1'b0; bb.miso = 1'b1;
    end else if (bb.sclk === 1'b1 && sb_sclk == 1'b0) begin
      sb_sclk = 1'b1;
      if (sb_bits < 8) sb_adr = {sb_adr[6:0], bb.mosi};
      sb_bits++;
      if (sb_bits == 8) sb_last = sb_adr;
    end else if (bb.sclk === 1'b0 && sb_sclk == 1'b1) begin
      sb_sclk = 1'b0;
      if (sb_bits >= 8 && sb_bits < 8 + NB && sb_adr == 8'h55)
        bb.miso = b_word[NB-1-(sb_bits-8)];
      else
        bb.miso = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle bus timing rules while cs is low.
  task automatic tmon_step(inout tmon_t t, input logic csv, input logic sv,
                           input logic mv, input int c);
    if (csv === 1'b0) t.cslow++;
    if (sv !== t.sp) begin
      check("sclk_phase_len", t.run, (t.sp === 1'b0 && t.first) ? 2 * c : c);
      if (t.sp === 1'b0) t.first = 1'b0;
      if (sv === 1'b1) t.rises++;
      t.run = 1;
      t.sp  = sv;
    end else begin
      t.run++;
    end
    if (mv !== t.mp) begin
      check("mosi_change_sclk_low", sv, 1'b0);
      t.mp = mv;
    end
  endtask

  task automatic tmon_init(output tmon_t t, input logic sv, input logic mv);
    t.run = 1; t.sp = sv; t.mp = mv; t.rises = 0; t.cslow = 1; t.first = 1'b1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pref = 1'b0;
    last_rdata = '0;
  endtask

  // Driver + checker for one transaction on the default build.
  task automatic serve_a(input int drop_at, input bit clear, output int won);
    int            g;
    int            n;
    bit            got;
    logic [7:0]    a;
    logic [NA-1:0] e;
    tmon_t         t;
    won = -1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (ba.cs === 1'b0);
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
      return;
    end
    g   = cyc;
    won = (ba.req0 === 1'b1 && ba.req1 === 1'b1) ? int'(pref) : ((ba.req1 === 1'b1) ? 1 : 0);
    pref = (won == 0);
    a   = (won == 1) ? ba.adr1 : ba.adr0;
    e   = mem_v[a] ? mem_a[a] : '1;
    exp_q.push_back(e);
    check("busy_at_grant", ba.busy, 1'b1);
    check("rdata_held", ba.rdata, last_rdata);
    check("grant_spacing", ((g - last_done) >= GA + 1) ? 1 : 0, 1);
    tmon_init(t, ba.sclk, ba.mosi);
    got = 1'b0;
    for (n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (drop_at > 0 && cyc - g == drop_at) begin
        if (won == 1) begin ba.req1 = 1'b0; ba.adr1 = ~ba.adr1; end
        else          begin ba.req0 = 1'b0; ba.adr0 = ~ba.adr0; end
      end
      got = (ba.done0 === 1'b1 || ba.done1 === 1'b1);
      if (!got) tmon_step(t, ba.cs, ba.sclk, ba.mosi, CA);
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    last_done = cyc;
    check("done_select", {ba.done1, ba.done0}, (won == 1) ? 2'b10 : 2'b01);
    check("rdata", ba.rdata, exp_q.pop_front());
    last_rdata = e;
    check("latency", cyc - g, 2 * CA * (9 + NA));
    check("cs_low_len", t.cslow, 2 * CA + 2 * CA * (8 + NA));
    check("cs_high_at_done", ba.cs, 1'b1);
    check("hold_len", t.run, CA);
    check("sclk_rises", t.rises, 8 + NA);
    check("mosi_address", sa_last, a);
    if (clear) begin
      if (won == 1) ba.req1 = 1'b0; else ba.req0 = 1'b0;
    end
    @(negedge clk);
    check("done_one_cycle", {ba.done1, ba.done0}, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of stimulus, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int  won;
    int  d0;
    int  g;
    bit  got;
    tmon_t t;
    ba.req0 = 1'b0; ba.req1 = 1'b0; ba.adr0 = '0; ba.adr1 = '0;
    bb.req0 = 1'b0; bb.req1 = 1'b0; bb.adr0 = '0; bb.adr1 = '0;
    b_word = 16'h1234;
    last_done = -1000;
    for (int i = 0; i < 256; i++) begin mem_v[i] = 1'b0; mem_a[i] = '0; end

    // Step 1: reset values.
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", ba.cs, 1'b1);
    check("rst_sclk", ba.sclk, 1'b0);
    check("rst_mosi", ba.mosi, 1'b0);
    check("rst_done0", ba.done0, 1'b0);
    check("rst_done1", ba.done1, 1'b0);
    check("rst_busy", ba.busy, 1'b0);
    check("rst_rdata", ba.rdata, '0);
    check("rst_cs_b", bb.cs, 1'b1);
    rst = 1'b1;
    pref = 1'b0;
    last_rdata = '0;

    // Step 2: single read from 0x01.
    mem_v[1] = 1'b1; mem_a[1] = 8'hA5;
    ba.adr0 = 8'h01; ba.req0 = 1'b1;
    serve_a(0, 1'b1, won);
    check("single_winner", won, 0);
    check("single_no_done1", dc1, 0);

    // Step 3: simultaneous requests after reset.
    reset_pulse();
    mem_a[1] = 8'h3C; mem_v[2] = 1'b1; mem_a[2] = 8'hC3;
    ba.adr0 = 8'h01; ba.adr1 = 8'h02; ba.req0 = 1'b1; ba.req1 = 1'b1;
    serve_a(0, 1'b1, won);
    check("contend_first", won, 0);
    serve_a(0, 1'b1, won);
    check("contend_second", won, 1);

    // Step 4: both held for four transactions.
    mem_v[8'h10] = 1'b1; mem_a[8'h10] = NA'($urandom);
    mem_v[8'h20] = 1'b1; mem_a[8'h20] = NA'($urandom);
    ba.adr0 = 8'h10; ba.adr1 = 8'h20; ba.req0 = 1'b1; ba.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve_a(0, 1'b0, won);
      check("fair_order", won, k % 2);
    end
    ba.req0 = 1'b0; ba.req1 = 1'b0;

    // Step 5: no responder; request and address dropped mid-transaction.
    mem_v[8'h7F] = 1'b0;
    ba.adr1 = 8'h7F; ba.req1 = 1'b1;
    serve_a(30, 1'b1, won);
    check("noslave_winner", won, 1);

    // Step 6: reset 20 cycles into a transaction.
    mem_v[8'h11] = 1'b1; mem_a[8'h11] = NA'($urandom);
    ba.adr0 = 8'h11; ba.req0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (ba.cs === 1'b0);
    end
    check("abort_grant_seen", got, 1'b1);
    d0 = dc0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_cs", ba.cs, 1'b1);
    check("abort_sclk", ba.sclk, 1'b0);
    check("abort_busy", ba.busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    pref = 1'b0;
    last_rdata = '0;
    serve_a(0, 1'b1, won);
    check("abort_rerun_winner", won, 0);
    check("abort_single_done", dc0 - d0, 1);

    // Step 7: random requests against random slave contents.
    for (int i = 0; i < 256; i++) begin
      mem_v[i] = ($urandom_range(0, 3) != 0);
      mem_a[i] = NA'($urandom);
    end
    for (int k = 0; k < 10; k++) begin
      if (ba.req0 !== 1'b1 && $urandom_range(0, 1) == 1) begin
        ba.adr0 = 8'($urandom_range(0, 255)); ba.req0 = 1'b1;
      end
      if (ba.req1 !== 1'b1 && $urandom_range(0, 1) == 1) begin
        ba.adr1 = 8'($urandom_range(0, 255)); ba.req1 = 1'b1;
      end
      if (ba.req0 !== 1'b1 && ba.req1 !== 1'b1) begin
        ba.adr0 = 8'($urandom_range(0, 255)); ba.req0 = 1'b1;
      end
      serve_a(($urandom_range(0, 3) == 0) ? 40 : 0, 1'b1, won);
    end
    ba.req0 = 1'b0; ba.req1 = 1'b0;

    // Step 8: CLKDIV=3, NBIT=16 build reads 0x1234 from 0x55.
    bb.adr0 = 8'h55; bb.req0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (bb.cs === 1'b0);
    end
    check("b_grant_seen", got, 1'b1);
    g = cyc;
    tmon_init(t, bb.sclk, bb.mosi);
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      got = (bb.done0 === 1'b1 || bb.done1 === 1'b1);
      if (!got) tmon_step(t, bb.cs, bb.sclk, bb.mosi, CB);
    end
    bb.req0 = 1'b0;
    check("b_done_select", {bb.done1, bb.done0}, 2'b01);
    check("b_rdata", bb.rdata, 16'h1234);
    check("b_latency", cyc - g, 2 * CB * (9 + NB));
    check("b_cs_low_len", t.cslow, 2 * CB + 2 * CB * (8 + NB));
    check("b_hold_len", t.run, CB);
    check("b_sclk_rises", t.rises, 8 + NB);
    check("b_mosi_address", sb_last, 8'h55);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
